// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - shared 33-bit adder-subtractor with round-robin arbitration and optional lock
module addsub_arbiter #(
   parameter int N_REQ    = 4,
   parameter int W        = 32,
   parameter int LOCK_TMO = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ-1:0]         req_sub,
   input  logic [N_REQ-1:0]         req_lock,
   input  logic [N_REQ*W-1:0]       req_a,
   input  logic [N_REQ*W-1:0]       req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic [W:0]               rsp_sum,
   output logic                     busy
);

   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = $clog2(LOCK_TMO + 1);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t           r_state, w_state_nxt;
   logic [IDW-1:0]   r_ptr, w_ptr_nxt;
   logic [IDW-1:0]   r_owner, w_owner_nxt;
   logic [CW-1:0]    r_idle_cnt, w_cnt_nxt;

   logic [IDW:0]     w_pick;
   logic [IDW-1:0]   w_sel;
   logic             w_sel_valid;
   logic             w_free;
   logic             w_accept;
   logic [W-1:0]     w_a, w_b;
   logic [W:0]       w_result;

   function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] id);
      return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
   endfunction

   // Returns {found, index} of the first valid requester at or after p, wrapping.
   function automatic logic [IDW:0] pick_rr(input logic [N_REQ-1:0] v, input logic [IDW-1:0] p);
      logic [IDW:0] res;
      int           k;
      res = '0;
      for (int i = 0; i < N_REQ; i++) begin
         k = (int'(p) + i) % N_REQ;
         if (!res[IDW] && v[k]) res = {1'b1, k[IDW-1:0]};
      end
      return res;
   endfunction

   assign w_pick      = pick_rr(req_valid, r_ptr);
   assign w_sel       = (r_state == S_LOCKED) ? r_owner : w_pick[IDW-1:0];
   assign w_sel_valid = (r_state == S_LOCKED) ? req_valid[r_owner] : w_pick[IDW];
   assign w_free      = !rsp_valid || rsp_ready;
   // Reset gates the grant so req_ready reads zero while rst_n is low.
   assign w_accept    = rst_n && w_free && w_sel_valid;
   assign req_ready   = w_accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_sel) : '0;

   assign w_a      = req_a[w_sel*W +: W];
   assign w_b      = req_b[w_sel*W +: W];
   assign w_result = req_sub[w_sel] ? ({1'b0, w_a} - {1'b0, w_b})
                                    : ({1'b0, w_a} + {1'b0, w_b});

   assign busy = rsp_valid || (r_state == S_LOCKED);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_idle_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_ptr_nxt = inc_id(w_sel);
               if (req_lock[w_sel]) begin
                  w_state_nxt = S_LOCKED;
                  w_owner_nxt = w_sel;
                  w_cnt_nxt   = '0;
               end
            end
         end
         S_LOCKED: begin
            // An owner accept takes priority over an expiring idle count.
            if (w_accept) begin
               w_ptr_nxt = inc_id(w_sel);
               w_cnt_nxt = '0;
               if (!req_lock[w_sel]) w_state_nxt = S_IDLE;
            end else if (r_idle_cnt == CW'(LOCK_TMO - 1)) begin
               w_state_nxt = S_IDLE;
               w_ptr_nxt   = inc_id(r_owner);
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_idle_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_owner    <= '0;
         r_idle_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_owner    <= w_owner_nxt;
         r_idle_cnt <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_id    <= '0;
      end else if (w_accept) begin
         rsp_valid <= 1'b1;
         rsp_sum   <= w_result;
         rsp_id    <= w_sel;
      end else if (w_free) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
